// File: rtl/block_lock_ctrl_pkg.sv
// Shared RX-recovery definitions: header encodings, offset range and lock FSM states.
package rx_recovery_pkg;

   localparam logic [1:0]  c_DATA_HEADER = 2'b01;
   localparam logic [1:0]  c_CMD_HEADER  = 2'b10;
   localparam int unsigned OFS_W         = 7;
   localparam int unsigned MAX_OFFSET    = 65;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   function automatic logic hdr_good(input logic [1:0] hdr);
      return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
   endfunction

endpackage

// File: rtl/block_lock_ctrl_hdr_err_monitor.sv
// Windowed header-error counter for the LOCKED state; requests unlock at the bad-header threshold.
module hdr_err_monitor #(
   parameter int unsigned WIN_BLOCKS = 1024,
   parameter int unsigned UNLOCK_THR = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic strobe,
   input  logic good,
   output logic unlock_req
);

   localparam int unsigned WIN_W = $clog2(WIN_BLOCKS) + 1;
   localparam int unsigned BAD_W = $clog2(UNLOCK_THR) + 1;

   logic [WIN_W-1:0] win_cnt;
   logic [BAD_W-1:0] bad_cnt;
   logic             wrap;
   logic             hit;

   assign wrap       = (win_cnt == WIN_W'(WIN_BLOCKS - 1));
   // A bad header on the wrap strobe still counts toward the closing window, so unlock wins.
   assign hit        = !good && (bad_cnt >= BAD_W'(UNLOCK_THR - 1));
   assign unlock_req = enable && strobe && hit;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         win_cnt <= '0;
         bad_cnt <= '0;
      end else if (strobe) begin
         win_cnt <= wrap ? '0 : win_cnt + WIN_W'(1);
         if (wrap) begin
            bad_cnt <= '0;
         end else if (!good && (bad_cnt < BAD_W'(UNLOCK_THR))) begin
            bad_cnt <= bad_cnt + BAD_W'(1);
         end
      end
   end

endmodule

// File: rtl/block_lock_ctrl.sv
// 66b block-lock sequencer (HUNT -> VERIFY -> LOCKED). Optional statistics ports via BLOCK_LOCK_STATS_EN.
module block_lock_ctrl
   import rx_recovery_pkg::*;
#(
   parameter int unsigned HUNT_BLOCKS = 32,
   parameter int unsigned LOCK_BLOCKS = 64,
   parameter int unsigned WIN_BLOCKS  = 1024,
   parameter int unsigned UNLOCK_THR  = 16,
   parameter int unsigned OFS_W       = rx_recovery_pkg::OFS_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             buffer_dv_i,
   input  logic [OFS_W-1:0] cand_offset_i,
   input  logic [1:0]       hdr_i,
   output logic             search_clr_o,
   output logic [OFS_W-1:0] offset_o,
   output logic             lock_o,
   output logic             lock_lost_o
`ifdef BLOCK_LOCK_STATS_EN
   ,
   output logic [15:0]      lock_loss_cnt_o,
   output logic [15:0]      verify_fail_cnt_o
`endif
);

   localparam int unsigned BLK_W  = $clog2(HUNT_BLOCKS) + 1;
   localparam int unsigned GOOD_W = $clog2(LOCK_BLOCKS) + 1;

   localparam logic [1:0] ST_HUNT   = HUNT;
   localparam logic [1:0] ST_VERIFY = VERIFY;
   localparam logic [1:0] ST_LOCKED = LOCKED;

   logic [1:0]        state;
   logic [BLK_W-1:0]  blk_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic              skip;
   logic              good;
   logic              cand_ok;
   logic              unlock_req;

   assign good    = hdr_good(hdr_i);
   assign cand_ok = (cand_offset_i <= OFS_W'(MAX_OFFSET));

   hdr_err_monitor #(
      .WIN_BLOCKS (WIN_BLOCKS),
      .UNLOCK_THR (UNLOCK_THR)
   ) u_mon (
      .clk        (clk_i),
      .rst        (rst_i),
      .enable     (state == ST_LOCKED),
      .strobe     (buffer_dv_i),
      .good       (good),
      .unlock_req (unlock_req)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_HUNT;
         blk_cnt      <= '0;
         good_cnt     <= '0;
         skip         <= 1'b0;
         offset_o     <= '0;
         lock_o       <= 1'b0;
         lock_lost_o  <= 1'b0;
         search_clr_o <= 1'b1;
      end else begin
         search_clr_o <= 1'b0;
         lock_lost_o  <= 1'b0;
         if (buffer_dv_i) begin
            case (state)
               ST_HUNT: begin
                  if (blk_cnt == BLK_W'(HUNT_BLOCKS - 1)) begin
                     blk_cnt <= '0;
                     if (cand_ok) begin
                        offset_o <= cand_offset_i;
                        good_cnt <= '0;
                        skip     <= 1'b1;
                        state    <= ST_VERIFY;
                     end else begin
                        search_clr_o <= 1'b1;
                     end
                  end else begin
                     blk_cnt <= blk_cnt + BLK_W'(1);
                  end
               end
               ST_VERIFY: begin
                  // First strobe after entry still carries headers from the old offset.
                  if (skip) begin
                     skip <= 1'b0;
                  end else if (!good) begin
                     good_cnt     <= '0;
                     search_clr_o <= 1'b1;
                     state        <= ST_HUNT;
                  end else if (good_cnt == GOOD_W'(LOCK_BLOCKS - 1)) begin
                     good_cnt <= '0;
                     lock_o   <= 1'b1;
                     state    <= ST_LOCKED;
                  end else begin
                     good_cnt <= good_cnt + GOOD_W'(1);
                  end
               end
               ST_LOCKED: begin
                  if (unlock_req) begin
                     lock_o       <= 1'b0;
                     lock_lost_o  <= 1'b1;
                     search_clr_o <= 1'b1;
                     state        <= ST_HUNT;
                  end
               end
               default: begin
                  blk_cnt <= '0;
                  state   <= ST_HUNT;
               end
            endcase
         end
      end
   end

`ifdef BLOCK_LOCK_STATS_EN
   logic vfail_evt;

   assign vfail_evt = buffer_dv_i && (state == ST_VERIFY) && !skip && !good;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_loss_cnt_o   <= '0;
         verify_fail_cnt_o <= '0;
      end else begin
         if (unlock_req && (lock_loss_cnt_o != '1)) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
         end
         if (vfail_evt && (verify_fail_cnt_o != '1)) begin
            verify_fail_cnt_o <= verify_fail_cnt_o + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Self-checking bench for block_lock_ctrl: phase table for acquisition paths, hand sequences for locked corners.
module tb_block_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dv = 1'b0;
   logic [6:0] cand = '0;
   logic [1:0] hdr = '0;
   logic       search_clr;
   logic [6:0] offset;
   logic       lock;
   logic       lock_lost;
`ifdef BLOCK_LOCK_STATS_EN
   logic [15:0] lock_loss_cnt;
   logic [15:0] verify_fail_cnt;
`endif

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned clr_pulses = 0;
   int unsigned lost_pulses = 0;

   always #5 clk = ~clk;

   block_lock_ctrl #(
      .HUNT_BLOCKS (32),
      .LOCK_BLOCKS (64),
      .WIN_BLOCKS  (1024),
      .UNLOCK_THR  (16),
      .OFS_W       (7)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .buffer_dv_i       (dv),
      .cand_offset_i     (cand),
      .hdr_i             (hdr),
      .search_clr_o      (search_clr),
      .offset_o          (offset),
      .lock_o            (lock),
      .lock_lost_o       (lock_lost)
`ifdef BLOCK_LOCK_STATS_EN
      ,
      .lock_loss_cnt_o   (lock_loss_cnt),
      .verify_fail_cnt_o (verify_fail_cnt)
`endif
   );

   always @(negedge clk) begin
      if (search_clr === 1'b1) clr_pulses++;
      if (lock_lost === 1'b1) lost_pulses++;
   end

   typedef struct {
      string       name;
      bit          do_rst;
      int unsigned n;
      int unsigned gap;
      logic [6:0]  cand;
      logic [1:0]  hdr;
      logic        exp_lock;
      logic [6:0]  exp_ofs;
      int unsigned exp_clr;
      int unsigned exp_lost;
   } phase_t;

   phase_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_strobe(input logic [6:0] c, input logic [1:0] h);
      @(negedge clk);
      dv = 1'b1;
      cand = c;
      hdr = h;
      @(posedge clk);
      #1;
      dv = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dv = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_pulses = 0;
      lost_pulses = 0;
   endtask

   task automatic acquire(input logic [6:0] c);
      do_reset();
      repeat (97) do_strobe(c, 2'b01);
      idle(1);
      #1;
      chk("acquire_lock", lock, 1);
      chk("acquire_ofs", offset, c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned drops;

      // Clean acquisition, strobe every 8 cycles.
      tbl.push_back('{"s1_reset",   1, 0,  0, 7'd0,  2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s1_hunt31",  0, 31, 7, 7'd17, 2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s1_sample",  0, 1,  7, 7'd17, 2'b01, 0, 7'd17, 1, 0});
      tbl.push_back('{"s1_ver64",   0, 64, 7, 7'd17, 2'b01, 0, 7'd17, 1, 0});
      tbl.push_back('{"s1_lock",    0, 1,  7, 7'd17, 2'b01, 1, 7'd17, 1, 0});
      // Verify failure on the 10th VERIFY strobe, then full re-acquisition.
      tbl.push_back('{"s2_reset",   1, 0,  0, 7'd0,  2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s2_sample",  0, 32, 1, 7'd33, 2'b01, 0, 7'd33, 1, 0});
      tbl.push_back('{"s2_ver9",    0, 9,  1, 7'd33, 2'b10, 0, 7'd33, 1, 0});
      tbl.push_back('{"s2_vfail",   0, 1,  1, 7'd33, 2'b11, 0, 7'd33, 2, 0});
      tbl.push_back('{"s2_hunt31",  0, 31, 1, 7'd40, 2'b01, 0, 7'd33, 2, 0});
      tbl.push_back('{"s2_resamp",  0, 1,  1, 7'd40, 2'b01, 0, 7'd40, 2, 0});
      tbl.push_back('{"s2_ver64",   0, 64, 0, 7'd40, 2'b01, 0, 7'd40, 2, 0});
      tbl.push_back('{"s2_relock",  0, 1,  0, 7'd40, 2'b01, 1, 7'd40, 2, 0});
      // Illegal candidate (66) rejected; 65 is the largest legal offset.
      tbl.push_back('{"s5_reset",   1, 0,  0, 7'd0,  2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s5_hunt31",  0, 31, 0, 7'd65, 2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s5_illegal", 0, 1,  0, 7'd66, 2'b01, 0, 7'd0,  2, 0});
      tbl.push_back('{"s5_hunt31b", 0, 31, 0, 7'd65, 2'b01, 0, 7'd0,  2, 0});
      tbl.push_back('{"s5_max_ok",  0, 1,  0, 7'd65, 2'b01, 0, 7'd65, 2, 0});
      tbl.push_back('{"s5_reset2",  1, 0,  0, 7'd0,  2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s5_hunt31c", 0, 31, 0, 7'd5,  2'b01, 0, 7'd0,  1, 0});
      tbl.push_back('{"s5_ill70",   0, 1,  0, 7'd70, 2'b01, 0, 7'd0,  2, 0});

      foreach (tbl[i]) begin
         if (tbl[i].do_rst) begin
            do_reset();
            chk({tbl[i].name, "_lock"}, lock, tbl[i].exp_lock);
            chk({tbl[i].name, "_ofs"}, offset, tbl[i].exp_ofs);
            chk({tbl[i].name, "_clr"}, search_clr, tbl[i].exp_clr);
            chk({tbl[i].name, "_lost"}, lock_lost, tbl[i].exp_lost);
         end else begin
            repeat (tbl[i].n) begin
               do_strobe(tbl[i].cand, tbl[i].hdr);
               idle(tbl[i].gap);
            end
            idle(1);
            #1;
            chk({tbl[i].name, "_lock"}, lock, tbl[i].exp_lock);
            chk({tbl[i].name, "_ofs"}, offset, tbl[i].exp_ofs);
            chk({tbl[i].name, "_clrcnt"}, clr_pulses, tbl[i].exp_clr);
            chk({tbl[i].name, "_lostcnt"}, lost_pulses, tbl[i].exp_lost);
         end
      end
      idle(1);
      #1;
      chk("post_reset_clr_low", search_clr, 0);

      // Error burst: 16 bad headers in one window, unlock exactly on the 16th.
      acquire(7'd9);
      for (int b = 0; b < 16; b++) begin
         repeat (3) do_strobe(7'd9, 2'b01);
         do_strobe(7'd9, (b % 2 == 0) ? 2'b00 : 2'b11);
         if (b == 14) begin
            chk("s3_15bad_lock", lock, 1);
            chk("s3_15bad_lost", lock_lost, 0);
            chk("s3_15bad_ofs", offset, 9);
         end else if (b == 15) begin
            chk("s3_16bad_lock", lock, 0);
            chk("s3_16bad_lost", lock_lost, 1);
            chk("s3_16bad_clr", search_clr, 1);
         end
      end
      idle(2);
      #1;
      chk("s3_lost_once", lost_pulses, 1);
      chk("s3_clr_count", clr_pulses, 2);
      chk("s3_lost_low", lock_lost, 0);
      chk("s3_still_unlocked", lock, 0);
`ifdef BLOCK_LOCK_STATS_EN
      chk("s3_loss_cnt", lock_loss_cnt, 1);
      chk("s3_vfail_cnt", verify_fail_cnt, 0);
`endif

      // Window tolerance: 15 bad per window for 4 windows, the 15th on the wrap strobe.
      acquire(7'd20);
      drops = 0;
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 1024; k++) begin
            do_strobe(7'd20, (((k % 50) == 7 && k < 700) || k == 1023) ? 2'b11 : 2'b01);
            if (lock !== 1'b1) drops++;
         end
      end
      idle(1);
      #1;
      chk("s4_lock_drops", drops, 0);
      chk("s4_lost_count", lost_pulses, 0);
      chk("s4_lock", lock, 1);
      chk("s4_ofs_held", offset, 20);

      // Mid-operation reset coincident with a strobe carrying a bad header.
      @(negedge clk);
      rst = 1'b1;
      dv = 1'b1;
      hdr = 2'b11;
      cand = 7'd20;
      @(posedge clk);
      #1;
      rst = 1'b0;
      dv = 1'b0;
      chk("s6_lock", lock, 0);
      chk("s6_ofs", offset, 0);
      chk("s6_lost", lock_lost, 0);
      chk("s6_clr", search_clr, 1);
`ifdef BLOCK_LOCK_STATS_EN
      chk("s6_loss_cnt", lock_loss_cnt, 0);
      chk("s6_vfail_cnt", verify_fail_cnt, 0);
`endif
      idle(1);
      #1;
      chk("s6_clr_low", search_clr, 0);
      repeat (32) do_strobe(7'd3, 2'b01);
      chk("s6_hunt_resample", offset, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
